// File: rtl/issue_select_pkg.sv
// Shared types and defaults for the issue-select stage of the scheduler.
package issue_select_pkg;

    localparam int NUM_ROWS_SCHED = 8;
    localparam int NUM_FUS        = 4;
    localparam int ROW_IDX_W      = $clog2(NUM_ROWS_SCHED);
    localparam int FU_IDX_W       = $clog2(NUM_FUS);
    localparam int PERF_W         = 32;

    // Per-FU select slot: empty, holding a grant, or cooling down after issue
    typedef enum logic [1:0] {SEL_IDLE, SEL_HOLD, SEL_BUSY} sel_state_t;

    // Saturating add used by the performance counters
    function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                  input logic [PERF_W-1:0] b);
        logic [PERF_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PERF_W] ? '1 : s[PERF_W-1:0];
    endfunction

endpackage

// File: rtl/issue_select_rr_arbiter.sv
// Round-robin picker: lowest-distance request starting at i_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_ROWS = 8
) (
    input  logic [NUM_ROWS-1:0]         i_req,
    input  logic [$clog2(NUM_ROWS)-1:0] i_ptr,
    output logic [NUM_ROWS-1:0]         o_gnt,
    output logic                        o_vld
);
    localparam int RW = $clog2(NUM_ROWS);

    logic [RW-1:0] w_idx;

    // Walk rows in priority order from the pointer; first hit wins
    always_comb begin
        o_gnt = '0;
        o_vld = 1'b0;
        w_idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            w_idx = RW'((int'(i_ptr) + i) % NUM_ROWS);
            if (!o_vld && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_vld        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_select.sv
// Issue select: one round-robin grant per FU from the wakeup request vector,
// valid/ready issue handshake, clear/free pulses back to wakeup on acceptance.
// Optional macro ISSUE_SELECT_PERF_CNT_EN adds perf_issue_cnt/perf_stall_cnt.
module issue_select #(
    parameter int NUM_ROWS = issue_select_pkg::NUM_ROWS_SCHED,
    parameter int NUM_FUS  = issue_select_pkg::NUM_FUS,
    parameter int OCC_W    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_ROWS-1:0]                  request_vector,
    input  logic [NUM_ROWS*$clog2(NUM_FUS)-1:0]  entry_fu,
    input  logic [NUM_FUS*OCC_W-1:0]             fu_occ,
    input  logic                                 flush,
    output logic [NUM_FUS-1:0]                   issue_valid,
    output logic [NUM_FUS*$clog2(NUM_ROWS)-1:0]  issue_row,
    input  logic [NUM_FUS-1:0]                   issue_ready,
    output logic [NUM_ROWS-1:0]                  clear_vec,
    output logic [NUM_ROWS-1:0]                  free_vec
`ifdef ISSUE_SELECT_PERF_CNT_EN
    ,
    output logic [31:0]                          perf_issue_cnt,
    output logic [31:0]                          perf_stall_cnt
`endif
);
    import issue_select_pkg::*;

    localparam int RW = $clog2(NUM_ROWS);
    localparam int FW = $clog2(NUM_FUS);

    logic [NUM_ROWS-1:0]               r_pending;
    logic [NUM_FUS-1:0]                w_hs;
    logic [NUM_FUS-1:0][NUM_ROWS-1:0]  w_hs_oh;
    logic [NUM_FUS-1:0][NUM_ROWS-1:0]  w_gnt_oh;
    logic [NUM_ROWS-1:0]               w_hs_rows;
    logic [NUM_ROWS-1:0]               w_gnt_rows;

    for (genvar f = 0; f < NUM_FUS; f++) begin : g_fu
        sel_state_t          r_state;
        sel_state_t          w_state_nxt;
        logic [RW-1:0]       r_row;
        logic [RW-1:0]       r_rr;
        logic [RW-1:0]       w_gnt_idx;
        logic [OCC_W-1:0]    r_busy;
        logic [OCC_W-1:0]    w_occ;
        logic [NUM_ROWS-1:0] w_elig;
        logic                w_slot_free;
        logic                w_take;

        assign w_occ                = fu_occ[f*OCC_W +: OCC_W];
        assign issue_valid[f]       = (r_state == SEL_HOLD);
        assign issue_row[f*RW +: RW] = r_row;
        assign w_hs[f]              = (r_state == SEL_HOLD) && issue_ready[f];
        assign w_hs_oh[f]           = w_hs[f] ? (NUM_ROWS'(1) << r_row) : '0;

        // Slot can take a new grant this cycle: empty, draining with no
        // occupancy (back-to-back), or in the last busy cycle
        always_comb begin
            w_slot_free = 1'b0;
            case (r_state)
                SEL_IDLE: w_slot_free = 1'b1;
                SEL_HOLD: w_slot_free = w_hs[f] && (w_occ == '0);
                SEL_BUSY: w_slot_free = (r_busy == OCC_W'(1));
                default:  w_slot_free = 1'b0;
            endcase
        end

        // Rows ready for this FU that are not already in flight
        always_comb begin
            w_elig = '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                w_elig[r] = request_vector[r] && !r_pending[r] &&
                            (entry_fu[r*FW +: FW] == FW'(f)) &&
                            w_slot_free && !flush;
            end
        end

        rr_arbiter #(.NUM_ROWS(NUM_ROWS)) u_arb (
            .i_req (w_elig),
            .i_ptr (r_rr),
            .o_gnt (w_gnt_oh[f]),
            .o_vld (w_take)
        );

        // One-hot grant to row index
        always_comb begin
            w_gnt_idx = '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (w_gnt_oh[f][r]) w_gnt_idx = RW'(r);
            end
        end

        // Slot FSM next state; flush forces IDLE
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                SEL_IDLE: if (w_take) w_state_nxt = SEL_HOLD;
                SEL_HOLD: if (w_hs[f]) begin
                    if (w_take)              w_state_nxt = SEL_HOLD;
                    else if (w_occ != '0)    w_state_nxt = SEL_BUSY;
                    else                     w_state_nxt = SEL_IDLE;
                end
                SEL_BUSY: if (r_busy == OCC_W'(1)) begin
                    w_state_nxt = w_take ? SEL_HOLD : SEL_IDLE;
                end
                default:  w_state_nxt = SEL_IDLE;
            endcase
            if (flush) w_state_nxt = SEL_IDLE;
        end

        // Slot registers: state, granted row, rr pointer, busy countdown
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= SEL_IDLE;
                r_row   <= '0;
                r_rr    <= '0;
                r_busy  <= '0;
            end else begin
                r_state <= w_state_nxt;
                if (flush)
                    r_busy <= '0;
                else if (w_hs[f] && (w_occ != '0))
                    r_busy <= w_occ;
                else if (r_state == SEL_BUSY)
                    r_busy <= r_busy - OCC_W'(1);
                if (w_take) begin
                    r_row <= w_gnt_idx;
                    r_rr  <= (w_gnt_idx == RW'(NUM_ROWS-1)) ? '0 : w_gnt_idx + RW'(1);
                end
            end
        end
    end

    // Collapse per-FU handshake and grant rows; entry_fu keeps them disjoint
    always_comb begin
        w_hs_rows  = '0;
        w_gnt_rows = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            w_hs_rows  = w_hs_rows  | w_hs_oh[f];
            w_gnt_rows = w_gnt_rows | w_gnt_oh[f];
        end
    end

    assign clear_vec = w_hs_rows;
    assign free_vec  = w_hs_rows;

    // In-flight mask: set on grant, cleared on acceptance or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pending <= '0;
        else if (flush)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_hs_rows) | w_gnt_rows;
    end

`ifdef ISSUE_SELECT_PERF_CNT_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] w_issue_inc;
    logic [31:0] w_stall_inc;

    assign w_issue_inc = 32'($countones(w_hs));
    assign w_stall_inc = 32'($countones(issue_valid & ~issue_ready));

    // Saturating counters of accepted issues and backpressured FU-cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_issue_cnt <= sat_add(r_issue_cnt, w_issue_inc);
            r_stall_cnt <= sat_add(r_stall_cnt, w_stall_inc);
        end
    end

    assign perf_issue_cnt = r_issue_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Consumer end of the scheduler wakeup/select interface. Takes the per-row `request_vector` from the wakeup logic and picks at most one ready entry per functional unit (FU) each cycle.
- Issues each picked entry to its FU over a valid/ready handshake.
- On issue acceptance, returns a clear pulse and a free pulse for that row to the wakeup logic. Clear wakes dependants; free recycles the entry.
- Sits between the wakeup logic and the FU issue ports in the backend scheduler.

Parameters:
- NUM_ROWS, 8, scheduler entries (rows of the dependency matrix)
- NUM_FUS, 4, functional units, one select port each
- OCC_W, 4, width of the per-FU occupancy (busy) counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- request_vector  in  NUM_ROWS  row r ready to issue (from wakeup)
- entry_fu  in  NUM_ROWS*clog2(NUM_FUS)  target FU index of each row, row r at slice r
- fu_occ  in  NUM_FUS*OCC_W  busy cycles after an accepted issue per FU; 0 = fully pipelined
- flush  in  1  squash all pending grants and busy counters
- issue_valid  out  NUM_FUS  grant held for FU f
- issue_row  out  NUM_FUS*clog2(NUM_ROWS)  granted row index per FU
- issue_ready  in  NUM_FUS  FU f accepts this cycle
- clear_vec  out  NUM_ROWS  one-hot-per-FU pulse: row's result broadcast to dependants
- free_vec  out  NUM_ROWS  pulse: row released to the free-entry queue

Behaviour:
- Reset: issue_valid=0, issue_row=0, clear_vec=0, free_vec=0, rr pointers=0, busy counters=0, pending mask=0.
- Eligibility: row r is eligible for FU f when request_vector[r]=1, entry_fu[r]=f, pending[r]=0, FU f slot is empty, and busy[f]=0.
- Selection: per FU, round-robin starting at rr_ptr[f]. Search order is rr_ptr[f], rr_ptr[f]+1, … with wrap modulo NUM_ROWS. The lowest-distance eligible row wins.
- Grant: registered, 1-cycle latency from request to issue_valid. On grant:
  - issue_valid[f]<=1, issue_row[f]<=r, pending[r]<=1;
  - rr_ptr[f]<=r+1 (wraps to 0 after NUM_ROWS-1).
- Per-FU state machine, states IDLE, HOLD, BUSY:
  - IDLE→HOLD on grant.
  - HOLD stays while issue_valid&&!issue_ready. issue_row stays stable and no new grant is made for FU f.
  - HOLD→IDLE on handshake when fu_occ[f]=0. A back-to-back grant in the same cycle is allowed: next row selected with the handshaking row excluded, so HOLD→HOLD.
  - HOLD→BUSY on handshake when fu_occ[f]>0. busy[f]<=fu_occ[f].
  - BUSY decrements each cycle and goes →IDLE when busy reaches 1.
- Handshake (issue_valid[f]&&issue_ready[f]): in the same cycle, clear_vec[row] and free_vec[row] are combinationally 1 and pending[row] clears at the edge. Zero cycles from acceptance to pulse.
- Simultaneous events:
  - Multiple FUs never grant the same row, because entry_fu is a single index.
  - A handshake and a new request for the same row in one cycle: the row is not re-granted (pending is still set that cycle).
- request_vector dropping while a row is in HOLD: the grant is kept. Wakeup guarantees no deassert except on flush.
- flush:
  - synchronous, highest priority;
  - next cycle all FUs go IDLE; issue_valid, pending and busy are 0; clear_vec and free_vec are 0;
  - rr pointers are kept;
  - a handshake in the flush cycle still pulses clear/free.
- Reset mid-HOLD: drops issue_valid immediately (async); nothing is freed.

Optional Feature:
- Macro: ISSUE_SELECT_PERF_CNT_EN.
- With the macro defined, two extra outputs are added, both reset to 0, saturating, 32 bits:
  - perf_issue_cnt: counts accepted issues summed across FUs, +popcount per cycle;
  - perf_stall_cnt: counts FU-cycles spent in HOLD with !issue_ready.
- Without it: no extra ports and no counter logic; behaviour is otherwise identical.

Decomposition:
- CORE_PKG holds NUM_ROWS_SCHED, NUM_FUS, ROW_IDX_W=$clog2(NUM_ROWS), FU_IDX_W=$clog2(NUM_FUS), and typedef enum logic[1:0] {SEL_IDLE, SEL_HOLD, SEL_BUSY} sel_state_t.
- One sub-module, rr_arbiter, is natural: parameterised NUM_ROWS, taking a request mask and a pointer and producing a one-hot grant plus a valid flag. It is instantiated once per FU.

Test Plan:
- Basic issue: request_vector=8'b0000_0100, entry_fu[2]=1, issue_ready[1]=1 → next cycle issue_valid[1]=1, issue_row[1]=2, and in that cycle clear_vec=free_vec=8'b0000_0100.
- Round-robin: rows 0, 3 and 5 request FU0 continuously, always ready, fu_occ=0 → issue_row[0] sequence is 0,3,5,0 on consecutive cycles.
- Backpressure: row 4 granted to FU2 with issue_ready[2]=0 for 3 cycles → issue_valid and issue_row=4 hold stable, free_vec stays 0 until ready; row 6 (FU2) is not granted meanwhile.
- Occupancy: fu_occ[3]=3, rows 1 and 7 request FU3 → row 1 issues, FU3 stays BUSY for 3 cycles, and row 7 appears on issue_valid[3] exactly 4 cycles after row 1's handshake.
- Flush: FUs 0 and 1 in HOLD, assert flush for 1 cycle → next cycle issue_valid=0, pending cleared, and no free_vec pulses for the squashed rows.
- Async reset mid-HOLD: assert rst between edges → issue_valid=0 immediately, and all outputs stay 0 until the first grant after release.
